mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM-stage consumer of the EX outputs (aluop, mem_addr, reg2, wd, wreg, wdata).
- Executes LB/LBU/LH/LHU/LW/SB/SH/SW over a word-wide req/ack data bus and raises a pipeline stall while a bus access is outstanding.
- Holds the MEM/WB pipeline register and drives writeback.
- Non-memory ops pass through with one register of latency.

Parameters:
- TIMEOUT_CYCLES, 16: bus cycles in BUS state without ack before abort; counter width = clog2(TIMEOUT_CYCLES)+1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- aluop_i  in  `ALU_OP_BUS  op from EX; memory ops are `LB_OP/`LBU_OP/`LH_OP/`LHU_OP/`LW_OP/`SB_OP/`SH_OP/`SW_OP
- mem_addr_i  in  32  effective byte address from EX
- reg2_i  in  32  store data source
- wd_i  in  5  destination register
- wreg_i  in  1  write enable from EX
- wdata_i  in  32  ALU result for non-memory ops
- bus_addr_o  out  32  word address {mem_addr[31:2],2'b00}
- bus_req_o  out  1  request, held until ack or abort
- bus_we_o  out  1  1 = write
- bus_sel_o  out  4  byte enables, sel[3] = bits 31:24
- bus_wdata_o  out  32  replicated store data
- bus_rdata_i  in  32  read data, valid with ack
- bus_ack_i  in  1  one-cycle completion
- stall_req_o  out  1  combinational; upstream holds EX outputs while 1
- wb_wd_o  out  5  registered writeback register
- wb_wreg_o  out  1  registered writeback enable
- wb_wdata_o  out  32  registered writeback data
- misalign_o  out  1  registered one-cycle pulse, misaligned access
- bus_err_o  out  1  registered one-cycle pulse, timeout abort

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0, all outputs 0.
- Byte order is big-endian: addr[1:0]=0 selects bits 31:24.
- States:
  - IDLE
  - BUS: bus_req_o=1, bus fields registered and stable.
- Non-memory aluop in IDLE: stall_req_o=0. Next edge: wb_* <= {wd_i, wreg_i, wdata_i}. Latency 1.
- Aligned memory op in IDLE:
  - stall_req_o=1.
  - Next edge: register bus_addr/we/sel/wdata, enter BUS, counter <= 0.
  - wb_wreg_o <= 0 (bubble).
- Alignment rules:
  - LH/LHU/SH need addr[0]=0.
  - LW/SW need addr[1:0]=0.
  - Byte ops are always aligned.
- Misaligned op in IDLE:
  - No bus access, stall_req_o=0.
  - Next edge: misalign_o <= 1, wb_wreg_o <= 0, wb_wd_o <= wd_i.
- Store encoding:
  - SB: sel = 4'b1000 >> addr[1:0], wdata = {4{reg2[7:0]}}.
  - SH: sel = addr[1] ? 4'b0011 : 4'b1100, wdata = {2{reg2[15:0]}}.
  - SW: sel = 4'b1111, wdata = reg2.
- Loads: bus_we_o=0, sel = 4'b1111.
- BUS state:
  - stall_req_o = ~bus_ack_i.
  - On an ack edge:
    - state <= IDLE, bus_req_o <= 0.
    - Load: wb_wdata_o <= extracted byte/half, sign-extended (LB/LH) or zero-extended (LBU/LHU), or full word (LW); wb_wreg_o <= wreg_i.
    - Store: wb_wreg_o <= 0.
  - Upstream advances on the same edge. Minimum memory-op latency is 2 cycles.
- Timeout:
  - Counter increments each BUS cycle without ack.
  - When counter = TIMEOUT_CYCLES-1 and no ack: stall_req_o=0 that cycle, bus_req_o <= 0, state <= IDLE, bus_err_o <= 1, wb_wreg_o <= 0.
  - Ack in that same cycle takes priority: normal completion, no error.
- Ack in IDLE is ignored.
- misalign_o and bus_err_o default to 0 every cycle they are not set.
- Reset asserted mid-BUS: immediate IDLE, bus_req_o=0; the access is dropped with no writeback.

Test Plan:
- ADDU result wdata_i=0x12345678, wd_i=3, wreg_i=1, no stall -> next cycle wb_wd_o=3, wb_wreg_o=1, wb_wdata_o=0x12345678; bus_req_o stays 0.
- LB addr 0x1001, ack 2 cycles after req with rdata 0x11F23344 -> bus_addr_o=0x1000, sel 1111, stall held 3 cycles, wb_wdata_o=0xFFFFFFF2; LBU same case -> 0x000000F2.
- SH addr 0x2002, reg2=0xAAAABEEF, immediate ack -> bus_we_o=1, sel=0011, bus_wdata_o=0xBEEFBEEF, wb_wreg_o=0, total 2 cycles.
- LW addr 0x3006 -> misalign_o pulses once, no bus_req_o, stall_req_o=0, wb_wreg_o=0.
- LW with no ack, TIMEOUT_CYCLES=4 -> bus_req_o high 4 cycles, then bus_err_o pulse, stall released, bus_req_o=0; repeat with ack on the 4th cycle -> normal load, no error.
- Reset pulled low during BUS -> bus_req_o, stall_req_o, and wb_* drop to 0 asynchronously; after release, an ADDU proceeds normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage: turns EX load/store ops into req/ack word-bus accesses, stalls the
// pipeline while an access is outstanding and holds the MEM/WB register.
`ifndef ALU_OP_BUS
`define ALU_OP_BUS 7:0
`define LB_OP  8'b11100000
`define LBU_OP 8'b11100100
`define LH_OP  8'b11100001
`define LHU_OP 8'b11100101
`define LW_OP  8'b11100011
`define SB_OP  8'b11101000
`define SH_OP  8'b11101001
`define SW_OP  8'b11101011
`endif

module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [`ALU_OP_BUS] aluop_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       bus_addr_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [31:0]       bus_wdata_o,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              stall_req_o,
  output logic [4:0]        wb_wd_o,
  output logic              wb_wreg_o,
  output logic [31:0]       wb_wdata_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic              dbg_state_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;

  // Bus handshake: bus_req_o rises with registered, stable addr/we/sel/wdata and
  // stays high until the single-cycle bus_ack_i (or a timeout abort) retires it.
  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [`ALU_OP_BUS] op_q;
  logic [1:0]        off_q;

  logic        is_load, is_store, aligned, last_cycle;
  logic [3:0]  st_sel;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    aligned  = 1'b1;
    case (aluop_i)
      `LB_OP, `LBU_OP: is_load = 1'b1;
      `LH_OP, `LHU_OP: begin is_load = 1'b1; aligned = ~mem_addr_i[0]; end
      `LW_OP:          begin is_load = 1'b1; aligned = (mem_addr_i[1:0] == 2'b00); end
      `SB_OP:          is_store = 1'b1;
      `SH_OP:          begin is_store = 1'b1; aligned = ~mem_addr_i[0]; end
      `SW_OP:          begin is_store = 1'b1; aligned = (mem_addr_i[1:0] == 2'b00); end
      default: ;
    endcase
  end

  always_comb begin
    st_sel   = 4'b1111;
    st_wdata = reg2_i;
    case (aluop_i)
      `SB_OP: begin
        st_sel   = 4'b1000 >> mem_addr_i[1:0];
        st_wdata = {4{reg2_i[7:0]}};
      end
      `SH_OP: begin
        st_sel   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        st_wdata = {2{reg2_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Big-endian lanes: byte offset 0 lives in bits 31:24.
  always_comb begin
    ld_byte = bus_rdata_i[31:24];
    case (off_q)
      2'd0: ld_byte = bus_rdata_i[31:24];
      2'd1: ld_byte = bus_rdata_i[23:16];
      2'd2: ld_byte = bus_rdata_i[15:8];
      2'd3: ld_byte = bus_rdata_i[7:0];
      default: ;
    endcase
    ld_half = off_q[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
    ld_data = bus_rdata_i;
    case (op_q)
      `LB_OP:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      `LBU_OP: ld_data = {24'd0, ld_byte};
      `LH_OP:  ld_data = {{16{ld_half[15]}}, ld_half};
      `LHU_OP: ld_data = {16'd0, ld_half};
      default: ;
    endcase
  end

  assign last_cycle = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Gated by rst so the stall drops together with the async reset.
  assign stall_req_o = rst & ((state_q == IDLE) ? ((is_load | is_store) & aligned)
                                                : (~bus_ack_i & ~last_cycle));

  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      off_q       <= 2'd0;
      bus_addr_o  <= 32'd0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= 4'd0;
      bus_wdata_o <= 32'd0;
      wb_wd_o     <= 5'd0;
      wb_wreg_o   <= 1'b0;
      wb_wdata_o  <= 32'd0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (is_load | is_store) begin
            wb_wreg_o <= 1'b0;
            if (aligned) begin
              state_q     <= BUS;
              cnt_q       <= '0;
              op_q        <= aluop_i;
              off_q       <= mem_addr_i[1:0];
              bus_req_o   <= 1'b1;
              bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
              bus_we_o    <= is_store;
              bus_sel_o   <= is_store ? st_sel : 4'b1111;
              bus_wdata_o <= is_store ? st_wdata : 32'd0;
            end else begin
              misalign_o <= 1'b1;
              wb_wd_o    <= wd_i;
            end
          end else begin
            wb_wd_o    <= wd_i;
            wb_wreg_o  <= wreg_i;
            wb_wdata_o <= wdata_i;
          end
        end
        BUS: begin
          if (bus_ack_i) begin
            state_q   <= IDLE;
            bus_req_o <= 1'b0;
            wb_wd_o   <= wd_i;
            if (bus_we_o) begin
              wb_wreg_o <= 1'b0;
            end else begin
              wb_wreg_o  <= wreg_i;
              wb_wdata_o <= ld_data;
            end
          end else if (last_cycle) begin
            state_q   <= IDLE;
            bus_req_o <= 1'b0;
            bus_err_o <= 1'b1;
            wb_wreg_o <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
